// File: rtl/pfpred_serializer_pkg.sv
// Local package for the prediction serializer: FSM state encoding,
// counter ceiling and the small arithmetic helpers used by the top.
package pfpred_serializer_pkg;

    typedef enum logic {
        PFS_IDLE  = 1'b0,
        PFS_ISSUE = 1'b1
    } pfs_state_t;

    localparam logic [15:0] PFS_CNT_MAX = 16'hFFFF;

    // Number of set bits in a 4-bit slot mask (0..4).
    function automatic logic [2:0] pfs_popcount4(input logic [3:0] m);
        pfs_popcount4 = {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
    endfunction

    // Add a small increment to a statistics counter, clamping at the ceiling
    // instead of wrapping back to zero.
    function automatic logic [15:0] pfs_sat_add(input logic [15:0] cnt, input logic [2:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {14'd0, inc};
        pfs_sat_add = sum[16] ? PFS_CNT_MAX : sum[15:0];
    endfunction

endpackage

// File: rtl/scmem_pkg.sv
// Shared scmem type package.
// Holds the field types exchanged between the prefetch monitor, the
// prefetch serializer and the core request path.
package scmem_pkg;

    typedef logic [5:0]  SC_robid_type;
    typedef logic [11:0] PF_delta_type;
    typedef logic [2:0]  PF_weigth_type;
    typedef logic [7:0]  PF_entry_type;

endpackage

// File: rtl/pfs_pick4.sv
// Combinational 4-bit lowest-set-bit priority picker.
// Ports:
//   req   - pending slot mask
//   grant - one-hot of the lowest set bit of req (zero when req is zero)
//   index - binary index of the granted bit (zero when req is zero)
module pfs_pick4 (
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] index
);

    // Slot 0 has the highest priority so slots leave in ascending order.
    always_comb begin
        grant = 4'b0000;
        index = 2'd0;
        if (req[0]) begin
            grant = 4'b0001;
            index = 2'd0;
        end else if (req[1]) begin
            grant = 4'b0010;
            index = 2'd1;
        end else if (req[2]) begin
            grant = 4'b0100;
            index = 2'd2;
        end else if (req[3]) begin
            grant = 4'b1000;
            index = 2'd3;
        end
    end

endmodule

// File: rtl/pfpred_serializer.sv
// Prediction packet serializer.
// Accepts a four-slot delta prediction packet from the prefetch monitor,
// drops slots whose weight is below PFS_WTHRESH or whose delta is zero,
// and issues the surviving slots one per cycle as single prefetch requests.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   pfmtocore_pred_*              - input packet (valid/retry handshake,
//                                   entry plus four rid/delta/weight slots)
//   pfs_flush                     - drop the held packet
//   pfstocore_req_*               - output request (valid/retry handshake,
//                                   entry, rid, delta, weight, source slot)
//   pfs_stat_issued/filtered      - saturating event counters
module pfpred_serializer
    import scmem_pkg::*;
    import pfpred_serializer_pkg::*;
#(
    parameter PF_weigth_type PFS_WTHRESH = 3'd1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pfmtocore_pred_valid,
    output logic          pfmtocore_pred_retry,
    input  PF_entry_type  pfmtocore_pred_pfentry,
    input  SC_robid_type  pfmtocore_pred_d0_rid,
    input  PF_delta_type  pfmtocore_pred_d0_val,
    input  PF_weigth_type pfmtocore_pred_d0_w,
    input  SC_robid_type  pfmtocore_pred_d1_rid,
    input  PF_delta_type  pfmtocore_pred_d1_val,
    input  PF_weigth_type pfmtocore_pred_d1_w,
    input  SC_robid_type  pfmtocore_pred_d2_rid,
    input  PF_delta_type  pfmtocore_pred_d2_val,
    input  PF_weigth_type pfmtocore_pred_d2_w,
    input  SC_robid_type  pfmtocore_pred_d3_rid,
    input  PF_delta_type  pfmtocore_pred_d3_val,
    input  PF_weigth_type pfmtocore_pred_d3_w,
    input  logic          pfs_flush,
    output logic          pfstocore_req_valid,
    input  logic          pfstocore_req_retry,
    output PF_entry_type  pfstocore_req_pfentry,
    output SC_robid_type  pfstocore_req_rid,
    output PF_delta_type  pfstocore_req_delta,
    output PF_weigth_type pfstocore_req_w,
    output logic [1:0]    pfstocore_req_slot,
    output logic [15:0]   pfs_stat_issued,
    output logic [15:0]   pfs_stat_filtered
);

    pfs_state_t    state;
    logic [3:0]    mask;
    PF_entry_type  held_entry;
    SC_robid_type  held_rid   [4];
    PF_delta_type  held_delta [4];
    PF_weigth_type held_w     [4];

    SC_robid_type  in_rid [4];
    PF_delta_type  in_val [4];
    PF_weigth_type in_w   [4];

    logic [3:0] qual;
    logic [3:0] grant;
    logic [1:0] pick_idx;
    logic       out_xfer;
    logic       last_xfer;
    logic       in_xfer;

    assign in_rid[0] = pfmtocore_pred_d0_rid;
    assign in_rid[1] = pfmtocore_pred_d1_rid;
    assign in_rid[2] = pfmtocore_pred_d2_rid;
    assign in_rid[3] = pfmtocore_pred_d3_rid;
    assign in_val[0] = pfmtocore_pred_d0_val;
    assign in_val[1] = pfmtocore_pred_d1_val;
    assign in_val[2] = pfmtocore_pred_d2_val;
    assign in_val[3] = pfmtocore_pred_d3_val;
    assign in_w[0]   = pfmtocore_pred_d0_w;
    assign in_w[1]   = pfmtocore_pred_d1_w;
    assign in_w[2]   = pfmtocore_pred_d2_w;
    assign in_w[3]   = pfmtocore_pred_d3_w;

    // A slot is worth issuing only if it is confident enough and actually
    // points somewhere other than the current line.
    always_comb begin
        qual = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            qual[n] = (in_w[n] >= PFS_WTHRESH) && (in_val[n] != '0);
        end
    end

    pfs_pick4 u_pick (
        .req   (mask),
        .grant (grant),
        .index (pick_idx)
    );

    assign out_xfer  = pfstocore_req_valid & ~pfstocore_req_retry;
    assign last_xfer = out_xfer & ((mask & ~grant) == 4'b0000);
    assign in_xfer   = pfmtocore_pred_valid & ~pfmtocore_pred_retry;

    // Back-pressure towards the monitor. The slot that is leaving this cycle
    // opens the door for the next packet combinationally, so a new packet can
    // follow the last request with no bubble. Reset and flush always block.
    always_comb begin
        pfmtocore_pred_retry = 1'b0;
        if (reset || pfs_flush) begin
            pfmtocore_pred_retry = 1'b1;
        end else if (state == PFS_ISSUE) begin
            pfmtocore_pred_retry = ~last_xfer;
        end
    end

    // Request payload always reflects the lowest pending slot of the held
    // packet; it is meaningless while the request is not valid.
    assign pfstocore_req_pfentry = held_entry;
    assign pfstocore_req_rid     = held_rid[pick_idx];
    assign pfstocore_req_delta   = held_delta[pick_idx];
    assign pfstocore_req_w       = held_w[pick_idx];
    assign pfstocore_req_slot    = pick_idx;

    // Serializer FSM. A flush wins over a packet arriving in the same cycle,
    // but a request that leaves during the flush still counts as issued.
    // A packet accepted while the last slot leaves replaces the old one
    // directly, without passing through IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= PFS_IDLE;
            mask                <= 4'b0000;
            pfstocore_req_valid <= 1'b0;
            pfs_stat_issued     <= 16'd0;
            pfs_stat_filtered   <= 16'd0;
        end else begin
            if (out_xfer) begin
                pfs_stat_issued <= pfs_sat_add(pfs_stat_issued, 3'd1);
            end
            if (pfs_flush) begin
                state               <= PFS_IDLE;
                mask                <= 4'b0000;
                pfstocore_req_valid <= 1'b0;
            end else if (in_xfer) begin
                held_entry <= pfmtocore_pred_pfentry;
                for (int n = 0; n < 4; n++) begin
                    held_rid[n]   <= in_rid[n];
                    held_delta[n] <= in_val[n];
                    held_w[n]     <= in_w[n];
                end
                mask              <= qual;
                pfs_stat_filtered <= pfs_sat_add(pfs_stat_filtered, 3'd4 - pfs_popcount4(qual));
                if (qual != 4'b0000) begin
                    state               <= PFS_ISSUE;
                    pfstocore_req_valid <= 1'b1;
                end else begin
                    state               <= PFS_IDLE;
                    pfstocore_req_valid <= 1'b0;
                end
            end else if (out_xfer) begin
                mask <= mask & ~grant;
                if (last_xfer) begin
                    state               <= PFS_IDLE;
                    pfstocore_req_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pfpred_serializer.sv
// Self-checking bench for pfpred_serializer. A behavioural model keeps the
// held packet as a queue of pending slot numbers plus integer counters.
module tb_pfpred_serializer;
    import scmem_pkg::*;

    localparam int WTHRESH = 1;
    localparam int CMAX    = 65535;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, pred_valid, flush, req_retry;
    PF_entry_type  in_entry;
    SC_robid_type  in_rid [4];
    PF_delta_type  in_val [4];
    PF_weigth_type in_w   [4];

    logic          pred_retry, req_valid;
    PF_entry_type  req_entry;
    SC_robid_type  req_rid;
    PF_delta_type  req_delta;
    PF_weigth_type req_w;
    logic [1:0]    req_slot;
    logic [15:0]   stat_issued, stat_filtered;

    pfpred_serializer #(.PFS_WTHRESH(3'd1)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .pfmtocore_pred_valid   (pred_valid),
        .pfmtocore_pred_retry   (pred_retry),
        .pfmtocore_pred_pfentry (in_entry),
        .pfmtocore_pred_d0_rid  (in_rid[0]),
        .pfmtocore_pred_d0_val  (in_val[0]),
        .pfmtocore_pred_d0_w    (in_w[0]),
        .pfmtocore_pred_d1_rid  (in_rid[1]),
        .pfmtocore_pred_d1_val  (in_val[1]),
        .pfmtocore_pred_d1_w    (in_w[1]),
        .pfmtocore_pred_d2_rid  (in_rid[2]),
        .pfmtocore_pred_d2_val  (in_val[2]),
        .pfmtocore_pred_d2_w    (in_w[2]),
        .pfmtocore_pred_d3_rid  (in_rid[3]),
        .pfmtocore_pred_d3_val  (in_val[3]),
        .pfmtocore_pred_d3_w    (in_w[3]),
        .pfs_flush              (flush),
        .pfstocore_req_valid    (req_valid),
        .pfstocore_req_retry    (req_retry),
        .pfstocore_req_pfentry  (req_entry),
        .pfstocore_req_rid      (req_rid),
        .pfstocore_req_delta    (req_delta),
        .pfstocore_req_w        (req_w),
        .pfstocore_req_slot     (req_slot),
        .pfs_stat_issued        (stat_issued),
        .pfs_stat_filtered      (stat_filtered)
    );

    // Reference model state
    int            q[$];
    PF_entry_type  m_entry;
    SC_robid_type  m_rid [4];
    PF_delta_type  m_val [4];
    PF_weigth_type m_w   [4];
    int            m_issued = 0;
    int            m_filtered = 0;
    logic          exp_valid, exp_retry;
    int            exp_slot;

    int n_checks = 0;
    int n_fails  = 0;

    // Quiet all inputs between scenarios.
    task automatic idle_inputs();
        reset = 1'b0; pred_valid = 1'b0; flush = 1'b0; req_retry = 1'b0;
    endtask

    // Put a packet on the input bus with the given weights and deltas.
    task automatic load_packet(input int w0, w1, w2, w3, v0, v1, v2, v3);
        in_entry = PF_entry_type'($urandom);
        in_w[0] = PF_weigth_type'(w0); in_w[1] = PF_weigth_type'(w1);
        in_w[2] = PF_weigth_type'(w2); in_w[3] = PF_weigth_type'(w3);
        in_val[0] = PF_delta_type'(v0); in_val[1] = PF_delta_type'(v1);
        in_val[2] = PF_delta_type'(v2); in_val[3] = PF_delta_type'(v3);
        for (int n = 0; n < 4; n++) in_rid[n] = SC_robid_type'($urandom);
    endtask

    // Go to the sampling point and derive what the outputs must be.
    task automatic settle();
        @(negedge clk);
        exp_valid = (q.size() != 0);
        exp_slot  = exp_valid ? q[0] : 0;
        exp_retry = reset || flush || (q.size() > 1) || (q.size() == 1 && req_retry);
    endtask

    // Take the clock edge and move the model forward by one cycle.
    task automatic advance();
        bit out_x, in_x;
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_issued = 0;
            m_filtered = 0;
        end else begin
            out_x = (q.size() != 0) && !req_retry;
            in_x  = pred_valid && !exp_retry;
            if (out_x) m_issued = (m_issued + 1 > CMAX) ? CMAX : m_issued + 1;
            if (flush) begin
                q.delete();
            end else begin
                if (out_x) void'(q.pop_front());
                if (in_x) begin
                    m_entry = in_entry;
                    for (int n = 0; n < 4; n++) begin
                        m_rid[n] = in_rid[n]; m_val[n] = in_val[n]; m_w[n] = in_w[n];
                        if (int'(in_w[n]) >= WTHRESH && in_val[n] != 0) q.push_back(n);
                    end
                    m_filtered = m_filtered + 4 - q.size();
                    if (m_filtered > CMAX) m_filtered = CMAX;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; pred_valid = 1'b1;
        load_packet(3, 3, 3, 3, 1, 2, 3, 4);
        for (int c = 0; c < 3; c++) begin
            settle();
            n_checks++;
            if (pred_retry !== 1'b1 || req_valid !== 1'b0 || stat_issued !== 16'd0 || stat_filtered !== 16'd0) begin
                n_fails++;
                $display("[TB] FAIL reset c=%0d: retry=%b valid=%b iss=%0d filt=%0d, want retry=1 valid=0 iss=0 filt=0",
                         c, pred_retry, req_valid, stat_issued, stat_filtered);
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_full_packet();
        int base = m_issued;
        for (int c = 0; c < 6; c++) begin
            pred_valid = (c == 0);
            if (c == 0) load_packet(3, 3, 3, 3, 1, 2, 3, 4);
            settle();
            n_checks++;
            if (req_valid !== exp_valid || pred_retry !== exp_retry || stat_issued !== 16'(m_issued)) begin
                n_fails++;
                $display("[TB] FAIL full_packet c=%0d: valid=%b retry=%b iss=%0d, want %b %b %0d",
                         c, req_valid, pred_retry, stat_issued, exp_valid, exp_retry, m_issued);
            end
            if (c >= 1 && c <= 4) begin
                n_checks++;
                if (req_valid !== 1'b1 || req_slot !== 2'(c - 1) || req_delta !== PF_delta_type'(c) ||
                    req_rid !== m_rid[c - 1] || req_entry !== m_entry) begin
                    n_fails++;
                    $display("[TB] FAIL full_packet_slot c=%0d: valid=%b slot=%0d delta=%0d, want 1 %0d %0d",
                             c, req_valid, req_slot, req_delta, c - 1, c);
                end
            end
            if (c == 4) begin
                n_checks++;
                if (pred_retry !== 1'b0) begin
                    n_fails++;
                    $display("[TB] FAIL full_packet_last_retry: retry=%b, want 0", pred_retry);
                end
            end
            if (c == 5) begin
                n_checks++;
                if (stat_issued !== 16'(base + 4)) begin
                    n_fails++;
                    $display("[TB] FAIL full_packet_issued: %0d, want %0d", stat_issued, base + 4);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_filter_mix();
        int base = m_filtered;
        for (int c = 0; c < 4; c++) begin
            pred_valid = (c == 0);
            if (c == 0) load_packet(2, 0, 5, 1, 7, 8, 9, 0);
            settle();
            n_checks++;
            if (req_valid !== exp_valid || pred_retry !== exp_retry || stat_filtered !== 16'(m_filtered) ||
                (exp_valid && (req_slot !== 2'(exp_slot) || req_delta !== m_val[exp_slot]))) begin
                n_fails++;
                $display("[TB] FAIL filter_mix c=%0d: valid=%b retry=%b slot=%0d filt=%0d, want %b %b %0d %0d",
                         c, req_valid, pred_retry, req_slot, stat_filtered, exp_valid, exp_retry, exp_slot, m_filtered);
            end
            if (c == 1 || c == 2) begin
                n_checks++;
                if (req_valid !== 1'b1 || req_slot !== ((c == 1) ? 2'd0 : 2'd2)) begin
                    n_fails++;
                    $display("[TB] FAIL filter_mix_slot c=%0d: valid=%b slot=%0d, want 1 %0d", c, req_valid, req_slot, (c == 1) ? 0 : 2);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (req_valid !== 1'b0 || stat_filtered !== 16'(base + 2)) begin
                    n_fails++;
                    $display("[TB] FAIL filter_mix_end: valid=%b filt=%0d, want 0 %0d", req_valid, stat_filtered, base + 2);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_all_filtered();
        int base = m_filtered;
        for (int c = 0; c < 7; c++) begin
            pred_valid = (c <= 1);
            if (c == 0) load_packet(0, 0, 0, 0, 1, 2, 3, 4);
            if (c == 1) load_packet(1, 1, 1, 1, 5, 6, 7, 8);
            settle();
            n_checks++;
            if (req_valid !== exp_valid || pred_retry !== exp_retry || stat_filtered !== 16'(m_filtered) ||
                (exp_valid && (req_slot !== 2'(exp_slot) || req_delta !== m_val[exp_slot] || req_w !== m_w[exp_slot]))) begin
                n_fails++;
                $display("[TB] FAIL all_filtered c=%0d: valid=%b retry=%b slot=%0d filt=%0d, want %b %b %0d %0d",
                         c, req_valid, pred_retry, req_slot, stat_filtered, exp_valid, exp_retry, exp_slot, m_filtered);
            end
            if (c == 1) begin
                n_checks++;
                if (req_valid !== 1'b0 || pred_retry !== 1'b0 || stat_filtered !== 16'(base + 4)) begin
                    n_fails++;
                    $display("[TB] FAIL all_filtered_next: valid=%b retry=%b filt=%0d, want 0 0 %0d",
                             req_valid, pred_retry, stat_filtered, base + 4);
                end
            end
            if (c == 2) begin
                n_checks++;
                if (req_valid !== 1'b1 || req_delta !== PF_delta_type'(5)) begin
                    n_fails++;
                    $display("[TB] FAIL all_filtered_second: valid=%b delta=%0d, want 1 5", req_valid, req_delta);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_req_retry_hold();
        for (int c = 0; c < 9; c++) begin
            pred_valid = (c == 0);
            if (c == 0) load_packet(4, 4, 4, 4, 11, 12, 13, 14);
            req_retry = (c >= 1 && c <= 3);
            settle();
            n_checks++;
            if (req_valid !== exp_valid || pred_retry !== exp_retry || stat_issued !== 16'(m_issued) ||
                (exp_valid && (req_slot !== 2'(exp_slot) || req_delta !== m_val[exp_slot] || req_rid !== m_rid[exp_slot]))) begin
                n_fails++;
                $display("[TB] FAIL retry_hold c=%0d: valid=%b retry=%b slot=%0d iss=%0d, want %b %b %0d %0d",
                         c, req_valid, pred_retry, req_slot, stat_issued, exp_valid, exp_retry, exp_slot, m_issued);
            end
            if (c >= 1 && c <= 3) begin
                n_checks++;
                if (req_valid !== 1'b1 || req_slot !== 2'd0 || req_delta !== PF_delta_type'(11) || pred_retry !== 1'b1) begin
                    n_fails++;
                    $display("[TB] FAIL retry_hold_stall c=%0d: valid=%b slot=%0d delta=%0d retry=%b, want 1 0 11 1",
                             c, req_valid, req_slot, req_delta, pred_retry);
                end
            end
            if (c >= 4 && c <= 7) begin
                n_checks++;
                if (req_valid !== 1'b1 || req_slot !== 2'(c - 4)) begin
                    n_fails++;
                    $display("[TB] FAIL retry_hold_order c=%0d: valid=%b slot=%0d, want 1 %0d", c, req_valid, req_slot, c - 4);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        int base = m_issued;
        for (int c = 0; c < 5; c++) begin
            pred_valid = (c == 0 || c == 2);
            if (c == 0) load_packet(2, 2, 2, 2, 21, 22, 23, 24);
            if (c == 2) load_packet(2, 2, 2, 2, 31, 32, 33, 34);
            flush = (c == 2);
            settle();
            n_checks++;
            if (req_valid !== exp_valid || pred_retry !== exp_retry || stat_issued !== 16'(m_issued) ||
                (exp_valid && (req_slot !== 2'(exp_slot) || req_delta !== m_val[exp_slot]))) begin
                n_fails++;
                $display("[TB] FAIL flush c=%0d: valid=%b retry=%b slot=%0d iss=%0d, want %b %b %0d %0d",
                         c, req_valid, pred_retry, req_slot, stat_issued, exp_valid, exp_retry, exp_slot, m_issued);
            end
            if (c == 2) begin
                n_checks++;
                if (pred_retry !== 1'b1) begin
                    n_fails++;
                    $display("[TB] FAIL flush_retry: retry=%b, want 1", pred_retry);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (req_valid !== 1'b0 || stat_issued !== 16'(base + 2)) begin
                    n_fails++;
                    $display("[TB] FAIL flush_after: valid=%b iss=%0d, want 0 %0d", req_valid, stat_issued, base + 2);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 4; c++) begin
            pred_valid = (c <= 1);
            if (c == 0) load_packet(1, 0, 0, 0, 31, 0, 0, 0);
            if (c == 1) load_packet(1, 0, 0, 0, 32, 0, 0, 0);
            settle();
            n_checks++;
            if (req_valid !== exp_valid || pred_retry !== exp_retry ||
                (exp_valid && (req_slot !== 2'(exp_slot) || req_delta !== m_val[exp_slot]))) begin
                n_fails++;
                $display("[TB] FAIL back_to_back c=%0d: valid=%b retry=%b delta=%0d, want %b %b",
                         c, req_valid, pred_retry, req_delta, exp_valid, exp_retry);
            end
            if (c == 1 || c == 2) begin
                n_checks++;
                if (req_valid !== 1'b1 || req_delta !== PF_delta_type'(30 + c) || (c == 1 && pred_retry !== 1'b0)) begin
                    n_fails++;
                    $display("[TB] FAIL back_to_back_seq c=%0d: valid=%b delta=%0d retry=%b, want 1 %0d",
                             c, req_valid, req_delta, pred_retry, 30 + c);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        bit hold = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!hold) begin
                pred_valid = ($urandom_range(0, 2) != 0);
                load_packet($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                            ($urandom_range(0, 4) == 0) ? 0 : $urandom, ($urandom_range(0, 4) == 0) ? 0 : $urandom,
                            ($urandom_range(0, 4) == 0) ? 0 : $urandom, ($urandom_range(0, 4) == 0) ? 0 : $urandom);
            end
            flush     = ($urandom_range(0, 19) == 0);
            req_retry = ($urandom_range(0, 3) == 0);
            settle();
            n_checks++;
            if (req_valid !== exp_valid || pred_retry !== exp_retry || stat_issued !== 16'(m_issued) ||
                stat_filtered !== 16'(m_filtered) ||
                (exp_valid && (req_slot !== 2'(exp_slot) || req_delta !== m_val[exp_slot] || req_rid !== m_rid[exp_slot] ||
                               req_w !== m_w[exp_slot] || req_entry !== m_entry))) begin
                n_fails++;
                $display("[TB] FAIL random c=%0d: valid=%b retry=%b slot=%0d iss=%0d filt=%0d, want %b %b %0d %0d %0d",
                         c, req_valid, pred_retry, req_slot, stat_issued, stat_filtered,
                         exp_valid, exp_retry, exp_slot, m_issued, m_filtered);
            end
            hold = pred_valid && exp_retry;
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_saturate_and_reset();
        for (int c = 0; c < 16397; c++) begin
            int k = c - 2;
            reset = (c < 2) || (k == 16390) || (k == 16391);
            pred_valid = (k >= 0 && k <= 16383) || k == 16386 || k == 16387 || k == 16388;
            if (k == 16383) load_packet(2, 0, 5, 1, 7, 8, 9, 0);
            else if (k == 16388) load_packet(3, 3, 3, 3, 1, 2, 3, 4);
            else load_packet(0, 0, 0, 0, 1, 2, 3, 4);
            settle();
            n_checks++;
            if (req_valid !== exp_valid || pred_retry !== exp_retry || stat_issued !== 16'(m_issued) ||
                stat_filtered !== 16'(m_filtered)) begin
                n_fails++;
                $display("[TB] FAIL saturate c=%0d: valid=%b retry=%b iss=%0d filt=%0d, want %b %b %0d %0d",
                         c, req_valid, pred_retry, stat_issued, stat_filtered, exp_valid, exp_retry, m_issued, m_filtered);
            end
            if (k == 16384 || k == 16387 || k == 16388) begin
                n_checks++;
                if (stat_filtered !== ((k == 16384) ? 16'hFFFE : 16'hFFFF)) begin
                    n_fails++;
                    $display("[TB] FAIL saturate_value k=%0d: filt=%h, want %h", k, stat_filtered,
                             (k == 16384) ? 16'hFFFE : 16'hFFFF);
                end
            end
            if (k == 16390 || k == 16391) begin
                n_checks++;
                if (pred_retry !== 1'b1 || (k == 16391 && (req_valid !== 1'b0 || stat_issued !== 16'd0 || stat_filtered !== 16'd0))) begin
                    n_fails++;
                    $display("[TB] FAIL mid_issue_reset k=%0d: retry=%b valid=%b iss=%0d filt=%0d",
                             k, pred_retry, req_valid, stat_issued, stat_filtered);
                end
            end
            if (k == 16392) begin
                n_checks++;
                if (pred_retry !== 1'b0 || req_valid !== 1'b0) begin
                    n_fails++;
                    $display("[TB] FAIL after_reset: retry=%b valid=%b, want 0 0", pred_retry, req_valid);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        load_packet(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_full_packet();
        test_filter_mix();
        test_all_filtered();
        test_req_retry_hold();
        test_flush();
        test_back_to_back();
        test_random();
        test_saturate_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
